// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback sequencer/arbiter.
package regfile_pkg;

  localparam int          ADDR_W   = 5;
  localparam int          DATA_W   = 32;
  localparam int          NUM_REGS = 32;
  localparam int          SP_IDX   = 2;
  localparam logic [31:0] SP_INIT  = 32'h0000_0024;

  typedef enum logic {WB_INIT, WB_ARB} wb_state_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from rr_ptr upward, pointer moves past the winner on advance.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic         adv,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] ptr_nxt;
  int            idx;

  // Walk the offsets downward so the smallest offset from rr_ptr wins.
  always_comb begin
    gnt     = '0;
    ptr_nxt = rr_ptr;
    idx     = 0;
    if (en) begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = (int'(rr_ptr) + k) % N;
        if (req[idx]) begin
          gnt      = '0;
          gnt[idx] = 1'b1;
          ptr_nxt  = PW'((idx + 1) % N);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (adv) begin
      rr_ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write port owner: post-reset clear sweep (SP preset), then round-robin writeback arbitration.
// Optional per-requester handshake counters on output grant_cnt when WB_ARB_COUNT_EN is defined.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int                NUM_REQ  = 3,
  parameter int                DATA_W   = regfile_pkg::DATA_W,
  parameter int                ADDR_W   = regfile_pkg::ADDR_W,
  parameter int                NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int                SP_IDX   = regfile_pkg::SP_IDX,
  parameter logic [DATA_W-1:0] SP_INIT  = regfile_pkg::SP_INIT,
  parameter int                GW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_rd,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        ru_wr,
  output logic [ADDR_W-1:0]           rd,
  output logic [DATA_W-1:0]           data_wr,
  output logic [GW-1:0]               grant_id,
  output logic                        init_done
`ifdef WB_ARB_COUNT_EN
  ,
  output logic [NUM_REQ*16-1:0]       grant_cnt
`endif
);

  // One extra bit so the index can step past NUM_REGS-1 and mark the sweep as finished.
  localparam int IW = ADDR_W + 1;

  function automatic logic [DATA_W-1:0] init_data(input logic [IW-1:0] idx);
    return (idx == IW'(SP_IDX)) ? SP_INIT : '0;
  endfunction

  wb_state_t           state, state_nxt;
  logic [IW-1:0]       init_idx, idx_nxt;
  logic                arb_en, hs;
  logic [GW-1:0]       sel;
  logic [ADDR_W-1:0]   sel_rd;
  logic [DATA_W-1:0]   sel_data;
  logic                wr_nxt, done_nxt;
  logic [ADDR_W-1:0]   rd_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic [GW-1:0]       gid_nxt;

  assign arb_en = rst_n && (state == WB_ARB);
  assign hs     = |(req_valid & req_ready);

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .en    (arb_en),
    .adv   (hs),
    .gnt   (req_ready)
  );

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) sel = GW'(i);
    end
  end

  assign sel_rd   = req_rd[int'(sel)*ADDR_W +: ADDR_W];
  assign sel_data = req_data[int'(sel)*DATA_W +: DATA_W];

  always_comb begin
    state_nxt = state;
    idx_nxt   = init_idx;
    done_nxt  = init_done;
    wr_nxt    = 1'b0;
    rd_nxt    = rd;
    data_nxt  = data_wr;
    gid_nxt   = grant_id;
    case (state)
      WB_INIT: begin
        if (init_idx == IW'(NUM_REGS)) begin
          state_nxt = WB_ARB;
          done_nxt  = 1'b1;
        end else begin
          wr_nxt   = 1'b1;
          rd_nxt   = init_idx[ADDR_W-1:0];
          data_nxt = init_data(init_idx);
          idx_nxt  = init_idx + 1'b1;
        end
      end
      WB_ARB: begin
        // A grant to x0 still consumes the handshake but the write never reaches the port.
        if (hs && (sel_rd != '0)) begin
          wr_nxt   = 1'b1;
          rd_nxt   = sel_rd;
          data_nxt = sel_data;
          gid_nxt  = sel;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= WB_INIT;
      init_idx  <= IW'(1);
      init_done <= 1'b0;
      ru_wr     <= 1'b0;
      rd        <= '0;
      data_wr   <= '0;
      grant_id  <= '0;
    end else begin
      state     <= state_nxt;
      init_idx  <= idx_nxt;
      init_done <= done_nxt;
      ru_wr     <= wr_nxt;
      rd        <= rd_nxt;
      data_wr   <= data_nxt;
      grant_id  <= gid_nxt;
    end
  end

`ifdef WB_ARB_COUNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic [15:0] cnt [NUM_REQ];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) cnt[i] <= sat_inc(cnt[i]);
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*16 +: 16] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: init sweep, directed handshakes, randomized arbitration against a queue-free reference model.
module tb_regfile_wb_arbiter;

  localparam int NUM_REQ  = 3;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int GW       = 2;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_rd = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      ru_wr;
  logic [ADDR_W-1:0]         rd;
  logic [DATA_W-1:0]         data_wr;
  logic [GW-1:0]             grant_id;
  logic                      init_done;
`ifdef WB_ARB_COUNT_EN
  logic [NUM_REQ*16-1:0]     grant_cnt;
`endif

  int vectors = 0;
  int errors  = 0;

  int                m_ptr = 0;
  logic [ADDR_W-1:0] m_last_rd = '0;
  logic [DATA_W-1:0] m_last_data = '0;
  logic [GW-1:0]     m_last_gid = '0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .req_ready (req_ready),
    .ru_wr     (ru_wr),
    .rd        (rd),
    .data_wr   (data_wr),
    .grant_id  (grant_id),
    .init_done (init_done)
`ifdef WB_ARB_COUNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  // Round-robin reference: first asserted requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int p);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int w);
    logic [NUM_REQ-1:0] r;
    r = '0;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  task automatic test_reset();
    logic [DATA_W-1:0] exp_d;
    rst_n = 1'b0;
    req_valid = '1; req_rd = '1; req_data = '1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({ru_wr, rd, data_wr, grant_id, init_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ru_wr=%0b rd=%0d data=%h gid=%0d done=%0b, want all zero",
               ru_wr, rd, data_wr, grant_id, init_done);
    end
    vectors++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL reset_ready got %b want 000", req_ready);
    end
    rst_n = 1'b1;
    for (int k = 1; k < NUM_REGS; k++) begin
      @(posedge clk); #1;
      exp_d = (k == 2) ? 32'h0000_0024 : 32'h0;
      vectors++;
      if (ru_wr !== 1'b1 || rd !== ADDR_W'(k) || data_wr !== exp_d || init_done !== 1'b0 || req_ready !== '0) begin
        errors++;
        $display("FAIL sweep[%0d] got ru_wr=%0b rd=%0d data=%h done=%0b ready=%b want 1 %0d %h 0 000",
                 k, ru_wr, rd, data_wr, init_done, req_ready, k, exp_d);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (init_done !== 1'b1 || ru_wr !== 1'b0) begin
      errors++;
      $display("FAIL sweep_done got done=%0b ru_wr=%0b want 1 0", init_done, ru_wr);
    end
    vectors++;
    if (req_ready !== 3'b001) begin
      errors++;
      $display("FAIL first_arb_ready got %b want 001", req_ready);
    end
    req_valid = '0;
    m_ptr = 0; m_last_rd = 5'd31; m_last_data = '0; m_last_gid = '0;
  endtask

  task automatic test_single();
    req_valid = 3'b001;
    req_rd[0 +: ADDR_W] = 5'd5;
    req_data[0 +: DATA_W] = 32'hDEADBEEF;
    #1;
    vectors++;
    if (req_ready !== onehot(model_pick(req_valid, m_ptr))) begin
      errors++;
      $display("FAIL single_ready got %b want %b", req_ready, onehot(model_pick(req_valid, m_ptr)));
    end
    @(posedge clk); #1;
    req_valid = '0;
    m_ptr = 1; m_last_rd = 5'd5; m_last_data = 32'hDEADBEEF; m_last_gid = 0;
    vectors++;
    if (ru_wr !== 1'b1 || rd !== 5'd5 || data_wr !== 32'hDEADBEEF || grant_id !== 0) begin
      errors++;
      $display("FAIL single_write got ru_wr=%0b rd=%0d data=%h gid=%0d want 1 5 deadbeef 0",
               ru_wr, rd, data_wr, grant_id);
    end
    @(posedge clk); #1;
    vectors++;
    if (ru_wr !== 1'b0 || rd !== 5'd5 || data_wr !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_idle got ru_wr=%0b rd=%0d data=%h want 0 5 deadbeef", ru_wr, rd, data_wr);
    end
  endtask

  task automatic test_rotate();
    int w;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rd[i*ADDR_W +: ADDR_W]   = ADDR_W'(i + 1);
      req_data[i*DATA_W +: DATA_W] = 32'hA000_0000 + i;
    end
    req_valid = '1;
    for (int c = 0; c < 6; c++) begin
      #1;
      w = model_pick(req_valid, m_ptr);
      vectors++;
      if (req_ready !== onehot(w)) begin
        errors++;
        $display("FAIL rotate_ready[%0d] got %b want %b", c, req_ready, onehot(w));
      end
      @(posedge clk); #1;
      m_ptr = (w + 1) % NUM_REQ;
      m_last_rd = ADDR_W'(w + 1); m_last_data = 32'hA000_0000 + w; m_last_gid = GW'(w);
      vectors++;
      if (ru_wr !== 1'b1 || grant_id !== m_last_gid || rd !== m_last_rd || data_wr !== m_last_data) begin
        errors++;
        $display("FAIL rotate_write[%0d] got ru_wr=%0b gid=%0d rd=%0d data=%h want 1 %0d %0d %h",
                 c, ru_wr, grant_id, rd, data_wr, m_last_gid, m_last_rd, m_last_data);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_rd0();
    req_valid = 3'b010;
    req_rd[1*ADDR_W +: ADDR_W] = '0;
    req_data[1*DATA_W +: DATA_W] = 32'h1234;
    #1;
    vectors++;
    if (req_ready !== 3'b010) begin
      errors++;
      $display("FAIL rd0_ready got %b want 010", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    m_ptr = 2;
    vectors++;
    if (ru_wr !== 1'b0) begin
      errors++;
      $display("FAIL rd0_dropped got ru_wr=%0b want 0", ru_wr);
    end
    req_valid = 3'b111;
    #1;
    vectors++;
    if (req_ready !== onehot(model_pick(req_valid, m_ptr))) begin
      errors++;
      $display("FAIL rd0_next_favours got %b want %b", req_ready, onehot(model_pick(req_valid, m_ptr)));
    end
    req_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] v;
    logic [ADDR_W-1:0]  wrd;
    int                 w;
    v = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!v[i] && ($urandom_range(0, 1) == 1)) begin
          v[i] = 1'b1;
          req_rd[i*ADDR_W +: ADDR_W]   = ($urandom_range(0, 5) == 0) ? '0 : ADDR_W'($urandom);
          req_data[i*DATA_W +: DATA_W] = $urandom;
        end
      end
      req_valid = v;
      #1;
      w = model_pick(v, m_ptr);
      vectors++;
      if (req_ready !== onehot(w)) begin
        errors++;
        $display("FAIL rand_ready[%0d] got %b want %b", c, req_ready, onehot(w));
      end
      wrd = (w >= 0) ? req_rd[w*ADDR_W +: ADDR_W] : '0;
      if (w >= 0 && wrd != '0) begin
        m_last_rd = wrd; m_last_data = req_data[w*DATA_W +: DATA_W]; m_last_gid = GW'(w);
      end
      @(posedge clk); #1;
      vectors++;
      if (ru_wr !== (w >= 0 && wrd != '0) || rd !== m_last_rd || data_wr !== m_last_data || grant_id !== m_last_gid) begin
        errors++;
        $display("FAIL rand_write[%0d] got ru_wr=%0b rd=%0d data=%h gid=%0d want %0b %0d %h %0d",
                 c, ru_wr, rd, data_wr, grant_id, (w >= 0 && wrd != '0), m_last_rd, m_last_data, m_last_gid);
      end
      if (w >= 0) begin
        v[w] = 1'b0;
        m_ptr = (w + 1) % NUM_REQ;
      end
    end
    req_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    req_valid = 3'b001;
    req_rd[0 +: ADDR_W] = 5'd9;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL mid_ready_in_reset got %b want 000", req_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (ru_wr !== 1'b0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_cancel got ru_wr=%0b done=%0b want 0 0", ru_wr, init_done);
    end
    req_valid = '0;
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (ru_wr !== 1'b1 || rd !== ADDR_W'(k)) begin
        errors++;
        $display("FAIL mid_sweep_a[%0d] got ru_wr=%0b rd=%0d want 1 %0d", k, ru_wr, rd, k);
      end
    end
    rst_n = 1'b0;
    req_valid = '1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (ru_wr !== 1'b0 || init_done !== 1'b0 || req_ready !== '0) begin
        errors++;
        $display("FAIL mid_held[%0d] got ru_wr=%0b done=%0b ready=%b want 0 0 000", k, ru_wr, init_done, req_ready);
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k < NUM_REGS; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (ru_wr !== 1'b1 || rd !== ADDR_W'(k) || req_ready !== '0) begin
        errors++;
        $display("FAIL mid_sweep_b[%0d] got ru_wr=%0b rd=%0d ready=%b want 1 %0d 000", k, ru_wr, rd, req_ready, k);
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    vectors++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL mid_done got %0b want 1", init_done);
    end
    m_ptr = 0; m_last_rd = 5'd31; m_last_data = '0; m_last_gid = '0;
  endtask

`ifdef WB_ARB_COUNT_EN
  task automatic test_counters();
    logic [NUM_REQ*16-1:0] exp_cnt;
    req_valid = 3'b010;
    req_rd[1*ADDR_W +: ADDR_W] = 5'd7;
    repeat (5) @(posedge clk);
    #1;
    req_valid = '0;
    exp_cnt = '0;
    exp_cnt[16 +: 16] = 16'd5;
    vectors++;
    if (grant_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL cnt_five got %h want %h", grant_cnt, exp_cnt);
    end
    req_valid = 3'b010;
    repeat (65540) @(posedge clk);
    #1;
    req_valid = '0;
    exp_cnt[16 +: 16] = 16'hFFFF;
    vectors++;
    if (grant_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL cnt_saturate got %h want %h", grant_cnt, exp_cnt);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_rotate();
    test_rd0();
    test_random();
    test_reset_mid();
`ifdef WB_ARB_COUNT_EN
    test_counters();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Sequencer and arbiter for the 32x32 register file write port (ru_wr/rd/data_wr). After reset it sweeps the register file: x1..x31 are cleared and the stack pointer is loaded with SP_INIT. It then shares the single write port between NUM_REQ writeback sources (ALU, load unit, CSR) using round-robin valid/ready arbitration. It sits between the execute/memory stages and the register file.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
DATA_W, 32, write data width
ADDR_W, 5, register index width
NUM_REGS, 32, registers swept during init
SP_IDX, 2, index of the stack pointer register
SP_INIT, 32'h0000_0024, stack pointer value written during init

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  reset, synchronous, active-low
req_valid  in  NUM_REQ  per-requester write request
req_rd  in  NUM_REQ*ADDR_W  per-requester destination index; requester i uses slice [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  per-requester write data; same slicing rule as req_rd
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
ru_wr  out  1  register file write enable, registered
rd  out  ADDR_W  register file write index, registered
data_wr  out  DATA_W  register file write data, registered
grant_id  out  $clog2(NUM_REQ)  source of the current ru_wr write, registered
init_done  out  1  high once the init sweep has completed

Behaviour:
- Reset (rst_n=0 at posedge):
  - state<=WB_INIT, init_idx<=1, rr_ptr<=0.
  - ru_wr=0, rd=0, data_wr=0, grant_id=0, init_done=0.
  - req_ready=0 (combinational, forced 0 while rst_n=0 or in WB_INIT).
- WB_INIT: every cycle drive ru_wr=1 and rd=init_idx.
  - data_wr = SP_INIT when init_idx==SP_IDX, otherwise 0.
  - init_idx increments by 1 each cycle. x0 is never written.
  - After the write of index NUM_REGS-1 is launched, the next posedge moves to WB_ARB and sets init_done=1 (sticky until reset).
  - The sweep takes NUM_REGS-1 cycles. Requests are held off: req_ready=0.
- WB_ARB: combinational round-robin grant among asserted req_valid bits.
  - Search starts at rr_ptr, wrapping modulo NUM_REQ. Exactly one winner gets req_ready=1.
  - Handshake occurs when req_valid[i] & req_ready[i] at a posedge.
  - Next cycle: ru_wr=1, rd=req_rd[i], data_wr=req_data[i], grant_id=i. Latency is 1 cycle; throughput is 1 write per cycle.
  - On handshake, rr_ptr<=(i+1) mod NUM_REQ. With no handshake, rr_ptr holds.
  - No handshake: ru_wr=0 next cycle; rd, data_wr and grant_id hold their previous values.
  - A request with rd==0 is accepted (ready=1, rr_ptr advances) but produces ru_wr=0: the write is dropped.
  - A requester must hold valid, rd and data stable until ready. The arbiter does not buffer; a non-granted requester simply waits.
  - Lone requester: granted every cycle, back-to-back.
- Reset mid-operation: any cycle with rst_n=0 aborts everything. A pending registered write is cancelled (ru_wr=0 next cycle). After release the sweep restarts from index 1.
- req_valid during WB_INIT is ignored and not latched.

Optional Feature:
- Macro: WB_ARB_COUNT_EN.
- Defined:
  - Adds output grant_cnt, NUM_REQ*16 bits.
  - Per-requester saturating 16-bit counters of accepted handshakes, including dropped rd==0 requests.
  - Counters reset to 0; a counter at 16'hFFFF stays at 16'hFFFF.
- Undefined: port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package regfile_pkg holds:
  - constants ADDR_W, DATA_W, NUM_REGS, SP_IDX, SP_INIT;
  - typedef enum logic {WB_INIT, WB_ARB} wb_state_t;
  - typedef logic [ADDR_W-1:0] reg_idx_t.
- Sub-module rr_arbiter (parameter N):
  - inputs: req vector, enable, advance;
  - output: one-hot grant;
  - owns the rr_ptr register and reuses the same synchronous active-low reset.
- Top level holds the init FSM, the output registers and the optional counters.

Test Plan:
- Reset release with no requests -> ru_wr=1 for 31 cycles, rd=1..31, data_wr=0 except rd=2 data_wr=32'h24. init_done=1 on the 32nd cycle; req_ready=0 throughout the sweep.
- After init, req0 valid with rd=5, data=32'hDEADBEEF -> req_ready[0]=1 same cycle. Next cycle ru_wr=1, rd=5, data_wr=32'hDEADBEEF, grant_id=0; the cycle after, ru_wr=0.
- req0..2 valid continuously (rd=1,2,3) -> grants rotate 0,1,2,0,1,2 with one write per cycle. grant_id follows the same order; no requester is starved.
- req1 valid with rd=0, data=32'h1234 -> req_ready[1]=1, next cycle ru_wr=0, rr_ptr=2 (the next grant favours req2).
- rst_n=0 while the sweep is at index 10, held 2 cycles -> ru_wr=0 and init_done=0 during reset; after release the sweep restarts at rd=1.
- With WB_ARB_COUNT_EN: 5 handshakes on req1 -> grant_cnt[1]=5, others 0. Forcing 65536+ handshakes saturates at 16'hFFFF.
